// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: cdb_packet_s broadcast packet, NUM_FU and the FU index constants.
package cdb_arbiter_pkg;

  localparam int NUM_FU  = 4;
  localparam int FU_ALU  = 0;
  localparam int FU_MULT = 1;
  localparam int FU_DIV  = 2;
  localparam int FU_MEM  = 3;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  // Result broadcast: reservation-station tag plus the result value.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_packet_s;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant/broadcast bundle between the functional units and the CDB arbiter.
// Latency: n/a (wires only); grant_o is combinational, cdb_* are registered in the arbiter.
// Backpressure: none; a requester holds its packet until it sees its grant bit.
// Ports (slave = arbiter side): req_valid_i, req_packet_i in; grant_o, cdb_valid_o,
//   cdb_packet_o, starve_force_o out. The master modport is the functional-unit side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU
);

  logic        [NUM_REQ-1:0] req_valid_i;
  cdb_packet_s [NUM_REQ-1:0] req_packet_i;
  logic        [NUM_REQ-1:0] grant_o;
  logic                      cdb_valid_o;
  cdb_packet_s               cdb_packet_o;
  logic                      starve_force_o;

  modport master (
    output req_valid_i, req_packet_i,
    input  grant_o, cdb_valid_o, cdb_packet_o, starve_force_o
  );

  modport slave (
    input  req_valid_i, req_packet_i,
    output grant_o, cdb_valid_o, cdb_packet_o, starve_force_o
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotate-priority one-hot picker: first set request at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: req_i request vector, ptr_i search start (must be < NUM_REQ), gnt_o one-hot or zero.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  int               pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap so non-power-of-two NUM_REQ never indexes past the vector.
      pos = int'(ptr_i) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = PTR_W'(pos);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional unit per cycle onto the common data bus.
// Latency: grant_o combinational in cycle N; broadcast registered, cdb_valid_o in N+1.
// Backpressure: none; the output register accepts a grant every cycle, flush_i kills the grant.
// Ports: clk_i, reset_i (async, active low), flush_i, bus (cdb_arbiter_if.slave).
// Option: define CDB_STARVE_GUARD_EN to add per-requester wait counters that force a grant
//   once a requester has waited STARVE_LIMIT cycles (lowest index wins ties).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_FU,
  parameter int STARVE_LIMIT = 8
) (
  input logic          clk_i,
  input logic          reset_i,
  input logic          flush_i,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PKT_W = $bits(cdb_packet_s);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("cdb_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  cdb_packet_s        cdb_packet_q, cdb_packet_d;
  logic [NUM_REQ-1:0] req_ok;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic               starve_force;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PKT_W-1:0]   gnt_pkt;

  // Reset and flush both mask every request, so nothing below can grant.
  assign req_ok = (reset_i && !flush_i) ? bus.req_valid_i : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i (req_ok),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

`ifdef CDB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   wait_q [NUM_REQ];
  logic [CNT_W-1:0]   wait_d [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] force_gnt;

  always_comb begin
    starved   = '0;
    force_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = req_ok[i] && (wait_q[i] == CNT_W'(STARVE_LIMIT));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (starved[i] && (force_gnt == '0)) force_gnt[i] = 1'b1;
    end
  end

  assign starve_force = |starved;
  assign gnt          = starve_force ? force_gnt : rr_gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (flush_i || gnt[i]) begin
        wait_d[i] = '0;
      end else if (req_ok[i] && (wait_q[i] != CNT_W'(STARVE_LIMIT))) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end
`else
  assign starve_force = 1'b0;
  assign gnt          = rr_gnt;
`endif

  // gnt is one-hot or zero, so OR-ing the selected packets is a plain mux.
  always_comb begin
    gnt_idx = '0;
    gnt_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
        gnt_pkt = gnt_pkt | bus.req_packet_i[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = |gnt;
    cdb_packet_d = cdb_packet_q;
    if (|gnt) begin
      rr_ptr_d     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      cdb_packet_d = cdb_packet_s'(gnt_pkt);
    end
  end

  // A broadcast already registered is left alone by flush; only reset discards it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_packet_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_packet_q <= cdb_packet_d;
    end
  end

  assign bus.grant_o        = gnt;
  assign bus.cdb_valid_o    = cdb_valid_q;
  assign bus.cdb_packet_o   = cdb_packet_q;
  assign bus.starve_force_o = starve_force;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(gnt));
  a_gnt_any     : assert property (@(posedge clk_i) (|req_ok) |-> (|gnt));

  // A waiting requester must keep its request and packet unchanged until granted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
    a_hold : assert property (@(posedge clk_i) disable iff (!reset_i)
      (bus.req_valid_i[gi] && !gnt[gi]) |=>
      (bus.req_valid_i[gi] && $stable(bus.req_packet_i[gi])));
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-FU requester queues, reference arbiter, broadcast scoreboard.
// Latency: expects grant in cycle N and the broadcast in N+1.
// Backpressure: requesters hold their packet until their grant bit is seen.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

`ifdef CDB_STARVE_GUARD_EN
  localparam int   SL       = 2;
  localparam logic EXP_DIVF = 1'b1;
`else
  localparam int   SL       = 8;
  localparam logic EXP_DIVF = 1'b0;
`endif

  logic clk_i;
  logic reset_i;
  logic flush_i;

  cdb_arbiter_if #(.NUM_REQ(4)) bus ();

  cdb_arbiter #(
    .NUM_REQ      (4),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  cdb_packet_s fuq [4][$];
  cdb_packet_s sb [$];
  cdb_packet_s last_pkt;
  int          m_ptr;
  int          m_cnt [4];
  logic [3:0]  last_grant;
  logic        last_force;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int fu, input logic [5:0] tag);
    cdb_packet_s p;
    p.tag  = tag;
    p.data = $urandom;
    fuq[fu].push_back(p);
  endtask

  function automatic logic fu_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (fuq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sb.delete();
    last_pkt = '0;
  endtask

  // Reference arbiter: starved requesters first (lowest index), otherwise round robin.
  function automatic void model_pick(input logic [3:0] v, input logic fl,
                                     output logic [3:0] g, output logic f);
    int idx;
    g = '0;
    f = 1'b0;
    if (!fl) begin
`ifdef CDB_STARVE_GUARD_EN
      for (int i = 0; i < 4; i++) begin
        if (!f && v[i] && m_cnt[i] == SL) begin
          g[i] = 1'b1;
          f    = 1'b1;
        end
      end
`endif
      if (!f) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (v[idx] && g == 4'b0000) g[idx] = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive(input logic fl);
    for (int i = 0; i < 4; i++) begin
      if (fuq[i].size() > 0) begin
        bus.req_valid_i[i]  = 1'b1;
        bus.req_packet_i[i] = fuq[i][0];
      end else begin
        bus.req_valid_i[i]  = 1'b0;
        bus.req_packet_i[i] = '0;
      end
    end
    flush_i = fl;
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic step(input logic fl, input logic rst_mid);
    logic [3:0]  v;
    logic [3:0]  g;
    logic        f;
    int          gi;
    cdb_packet_s p;
    drive(fl);
    v = bus.req_valid_i;
    #1;
    model_pick(v, fl, g, f);
    chk("grant", bus.grant_o, g);
    chk("starve_force", bus.starve_force_o, f);
    last_grant = bus.grant_o;
    last_force = bus.starve_force_o;
    gi = -1;
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    if (gi >= 0) begin
      sb.push_back(fuq[gi][0]);
      m_ptr = (gi + 1) % 4;
    end
`ifdef CDB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      if (fl || g[i]) m_cnt[i] = 0;
      else if (v[i] && m_cnt[i] < SL) m_cnt[i]++;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (bus.grant_o[i] && fuq[i].size() > 0) void'(fuq[i].pop_front());
    end
    @(posedge clk_i);
    #1;
    if (sb.size() > 0) begin
      p = sb.pop_front();
      chk("cdb_valid", bus.cdb_valid_o, 1'b1);
      chk("cdb_packet", bus.cdb_packet_o, p);
      last_pkt = p;
    end else begin
      chk("cdb_valid_idle", bus.cdb_valid_o, 1'b0);
      chk("cdb_packet_hold", bus.cdb_packet_o, last_pkt);
    end
    if (rst_mid) begin
      #2;
      reset_i = 1'b0;
      #1;
      chk("rst_cdb_valid", bus.cdb_valid_o, 1'b0);
      chk("rst_cdb_packet", bus.cdb_packet_o, '0);
      chk("rst_grant", bus.grant_o, 4'b0000);
      chk("rst_force", bus.starve_force_o, 1'b0);
      m_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
    end else begin
      @(negedge clk_i);
    end
  endtask

  task automatic drain();
    for (int s = 0; s < 40 && fu_busy(); s++) step(1'b0, 1'b0);
    chk("drain_done", fu_busy(), 1'b0);
  endtask

  int   waits;
  logic div_done;
  logic div_force;

  initial begin
    reset_i          = 1'b0;
    flush_i          = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_packet_i = '0;
    last_grant       = '0;
    last_force       = 1'b0;
    m_reset();

    // Reset state with every requester already asserting.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) load(i, 6'(k * 4 + i));
    repeat (2) @(negedge clk_i);
    drive(1'b0);
    #1;
    chk("reset_grant", bus.grant_o, 4'b0000);
    chk("reset_cdb_valid", bus.cdb_valid_o, 1'b0);
    chk("reset_cdb_packet", bus.cdb_packet_o, '0);
    chk("reset_force", bus.starve_force_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // All four requesting from reset: rotation starts at index 0.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0);
`ifndef CDB_STARVE_GUARD_EN
      chk("rr_seq", last_grant, 4'b0001 << (k % 4));
`endif
    end
    drain();
    step(1'b0, 1'b0);

    // MEM alone, then ALU and MEM together: pointer wrapped to 0.
    load(FU_MEM, 6'h09);
    step(1'b0, 1'b0);
    chk("mem_only_grant", last_grant, 4'b1000);
    load(FU_ALU, 6'h11);
    load(FU_MEM, 6'h13);
    step(1'b0, 1'b0);
    chk("ptr_after_mem", last_grant, 4'b0001);
    step(1'b0, 1'b0);

    // Flush: ALU granted first (pointer at 1), then flush while that broadcast is out.
    load(FU_ALU, 6'h21);
    step(1'b0, 1'b0);
    load(FU_ALU, 6'h22);
    load(FU_MULT, 6'h23);
    flush_i = 1'b1;
    #1;
    chk("flush_keeps_bcast", bus.cdb_valid_o, 1'b1);
    step(1'b1, 1'b0);
    chk("flush_grant", last_grant, 4'b0000);
    step(1'b0, 1'b0);
    chk("post_flush_grant", last_grant, 4'b0010);
    step(1'b0, 1'b0);

    // DIV waits while MEM and ALU keep winning from pointer 3.
    load(FU_DIV, 6'h30);
    step(1'b0, 1'b0);
    load(FU_ALU, 6'h31);
    load(FU_ALU, 6'h35);
    load(FU_MEM, 6'h33);
    load(FU_MEM, 6'h37);
    load(FU_DIV, 6'h32);
    waits     = 0;
    div_done  = 1'b0;
    div_force = 1'b0;
    for (int s = 0; s < 10 && !div_done; s++) begin
      step(1'b0, 1'b0);
      if (last_grant[FU_DIV]) begin
        div_done  = 1'b1;
        div_force = last_force;
      end else begin
        waits++;
      end
    end
    chk("div_granted", div_done, 1'b1);
    chk("div_wait_cycles", waits, 2);
    chk("div_forced", div_force, EXP_DIVF);
    drain();

    // Reset mid-cycle while DIV's broadcast is on the bus; restart from index 0.
    load(FU_MULT, 6'h40);
    step(1'b0, 1'b0);
    load(FU_ALU, 6'h41);
    load(FU_DIV, 6'h42);
    load(FU_MEM, 6'h43);
    step(1'b0, 1'b1);
    chk("pre_rst_grant", last_grant, 4'b0100);
    step(1'b0, 1'b0);
    chk("rst_restart_grant", last_grant, 4'b0001);
    drain();
    step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of functional-unit requesters, index 0=ALU, 1=MULT, 2=DIV, 3=MEM.
REQ-002 Parameter STARVE_LIMIT, default 8: wait cycles after which a requester is forced to win (only with CDB_STARVE_GUARD_EN).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  branch-mispredict flush; kills arbitration and the output stage.
REQ-006 req_valid_i  input  NUM_REQ  per-FU result-ready request.
REQ-007 req_packet_i  input  NUM_REQ x cdb_packet_s  per-FU result packet, held stable while requesting.
REQ-008 grant_o  input-side reply, output  NUM_REQ  one-hot or zero; combinational grant this cycle.
REQ-009 cdb_valid_o  output  1  broadcast valid on the common data bus.
REQ-010 cdb_packet_o  output  cdb_packet_s  broadcast packet, registered.
REQ-011 starve_force_o  output  1  current grant was forced by the starvation guard (tied 0 without macro).

Function
REQ-012 grant_o SHALL have at most one bit set, and exactly one when any req_valid_i bit is 1 and flush_i is 0.
REQ-013 Arbitration SHALL be round-robin: search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first valid wins.
REQ-014 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ at the next edge; with no grant rr_ptr SHALL hold.
REQ-015 Latency: a packet granted in cycle N SHALL appear on cdb_packet_o with cdb_valid_o=1 in cycle N+1 exactly once.
REQ-016 With no grant in cycle N, cdb_valid_o SHALL be 0 in N+1 and cdb_packet_o SHALL hold its previous value.
REQ-017 Handshake: a requester SHALL keep req_valid_i and req_packet_i stable until it sees its grant_o bit; on grant it drops or presents a new packet next cycle. Arbiter never drops a granted packet.
REQ-018 No backpressure: the output stage SHALL accept a grant every cycle.
REQ-019 flush_i=1 in cycle N: grant_o SHALL be 0 in N, cdb_valid_o SHALL be 0 in N+1, rr_ptr SHALL hold, starvation counters SHALL clear.
REQ-020 flush_i asserted while cdb_valid_o=1 SHALL NOT suppress that already-registered broadcast in the same cycle.
REQ-021 rr_ptr SHALL be $clog2(NUM_REQ) bits and wrap from NUM_REQ-1 to 0; NUM_REQ not a power of two SHALL wrap explicitly.

Reset
REQ-022 reset_i low SHALL immediately force cdb_valid_o=0, cdb_packet_o=0, rr_ptr=0, all starvation counters=0, starve_force_o=0.
REQ-023 grant_o SHALL be 0 while reset_i is low; reset mid-stream SHALL discard any in-flight broadcast.
REQ-024 First grant after reset release SHALL follow round-robin from index 0.

Configuration
REQ-025 Macro CDB_STARVE_GUARD_EN: when defined, each requester has a wait counter (width $clog2(STARVE_LIMIT+1)) incrementing each cycle it is valid and not granted, saturating at STARVE_LIMIT, cleared on grant.
REQ-026 With CDB_STARVE_GUARD_EN, any requester whose counter equals STARVE_LIMIT SHALL win over round-robin; ties resolve lowest index; starve_force_o=1 that cycle; rr_ptr updates per REQ-014.
REQ-027 Without CDB_STARVE_GUARD_EN, counters SHALL not exist, arbitration is pure round-robin, starve_force_o tied 0.

Structure
REQ-028 cdb_packet_s, NUM_FU and FU index constants (FU_ALU..FU_MEM) SHALL reside in the shared structs package.
REQ-029 One sub-module rr_pick (rotate-priority one-hot picker, parameterised NUM_REQ) SHALL implement the combinational search; counters and output register stay in cdb_arbiter.

Verification
REQ-030 Reset then all four valid constantly for 8 cycles -> grants 0,1,2,3,0,1,2,3; cdb_packet_o tags match one cycle later.
REQ-031 Only MEM(3) valid with tag 0x9 in cycle 5 -> grant_o=4'b1000 in cycle 5, cdb_valid_o=1 tag 0x9 in cycle 6, rr_ptr=0 after.
REQ-032 Requests on ALU and MULT, flush_i=1 in cycle N -> grant_o=0 in N, cdb_valid_o=0 in N+1, next grant from unchanged rr_ptr.
REQ-033 reset_i driven low asynchronously mid-cycle while cdb_valid_o=1 -> cdb_valid_o drops before next clock edge, rr_ptr=0.
REQ-034 With CDB_STARVE_GUARD_EN, STARVE_LIMIT=2, DIV valid continuously while rr_ptr is repeatedly re-aimed by other winners -> DIV granted no later than its 3rd waiting cycle with starve_force_o=1.
REQ-035 Held request check: ALU packet changes before grant -> assertion fires; ungranted packets never appear on cdb_packet_o.
